// File: rtl/aidc_lite_cfg_pkg.sv
// aidc_lite_cfg_pkg: register map, status bit positions and channel status type
package aidc_lite_cfg_pkg;
    localparam logic [3:0] REG_SRC      = 4'h0;
    localparam logic [3:0] REG_DST      = 4'h1;
    localparam logic [3:0] REG_LEN      = 4'h2;
    localparam logic [3:0] REG_CTRL     = 4'h3;
    localparam logic [3:0] REG_STATUS   = 4'h4;
    localparam logic [3:0] REG_IRQ_EN   = 4'h5;
    localparam logic [3:0] REG_IRQ_STAT = 4'h0;
    localparam logic [3:0] GLOBAL_PAGE  = 4'hF;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    typedef struct packed {
        logic err;
        logic done;
        logic busy;
    } chan_status_t;
endpackage

// File: rtl/aidc_lite_comp_cfg_mc_if.sv
// APB_INTF: zero-wait APB slave bus carrying the 10-bit register window
interface APB_INTF;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready);
endinterface

// File: rtl/aidc_lite_cfg_chan.sv
// aidc_lite_cfg_chan: one channel's config registers, start/busy/done/err and IRQ_EN
// IRQ_EN storage exists only when AIDC_LITE_CFG_IRQ_EN is defined
module aidc_lite_cfg_chan
    import aidc_lite_cfg_pkg::*;
#(
    parameter int LEN_LSB = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [3:0]         rg,
    input  logic [31:0]        wdata,
    input  logic               done_in,
    output logic [31:0]        src,
    output logic [31:0]        dst,
    output logic [31:LEN_LSB]  len,
    output logic               start,
    output chan_status_t       st,
    output logic               irq_en
);
    logic wr_cfg, req, acc, w1c;
    assign wr_cfg = we && (rg == REG_SRC || rg == REG_DST || rg == REG_LEN);
    assign req    = we && rg == REG_CTRL && wdata[0];
    assign acc    = req && !st.busy;
    assign w1c    = we && rg == REG_STATUS;
    // busy is sampled before done_in, so a start colliding with done is rejected
    always_ff @(posedge clk) begin
        if (rst) begin
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            start <= 1'b0;
            st    <= '0;
        end else begin
            start   <= acc;
            st.busy <= acc | (st.busy & ~done_in);
            st.done <= done_in | (st.done & ~(w1c & wdata[ST_DONE]));
            st.err  <= (st.busy & (req | wr_cfg)) | (st.err & ~(w1c & wdata[ST_ERR]));
            if (wr_cfg && !st.busy) begin
                src <= rg == REG_SRC ? wdata : src;
                dst <= rg == REG_DST ? wdata : dst;
                len <= rg == REG_LEN ? wdata[31:LEN_LSB] : len;
            end
        end
    end
`ifdef AIDC_LITE_CFG_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq_en <= 1'b0;
        else if (we && rg == REG_IRQ_EN) irq_en <= wdata[0];
    end
`else
    assign irq_en = 1'b0;
`endif
endmodule

// File: rtl/aidc_lite_comp_cfg_mc.sv
// aidc_lite_comp_cfg_mc: APB decode, read mux and irq aggregation over CH_CNT channels
// Interrupt logic is built only when AIDC_LITE_CFG_IRQ_EN is defined
module aidc_lite_comp_cfg_mc
    import aidc_lite_cfg_pkg::*;
#(
    parameter int CH_CNT  = 4,
    parameter int LEN_LSB = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    APB_INTF.slave                           apb_if,
    output logic [CH_CNT-1:0][31:0]          src_addr_o,
    output logic [CH_CNT-1:0][31:0]          dst_addr_o,
    output logic [CH_CNT-1:0][31:LEN_LSB]    len_o,
    output logic [CH_CNT-1:0]                start_o,
    input  logic [CH_CNT-1:0]                done_i,
    output logic                             irq_o
);
    logic [3:0]        ch, rg;
    logic              commit, setup;
    logic [31:0]       rdata;
    logic [CH_CNT-1:0] irq_en, irq_stat;
    chan_status_t      st [CH_CNT];
    assign ch            = apb_if.paddr[9:6];
    assign rg            = apb_if.paddr[5:2];
    assign commit        = apb_if.psel & apb_if.penable & apb_if.pwrite;
    assign setup         = apb_if.psel & ~apb_if.penable & ~apb_if.pwrite;
    assign apb_if.pready = 1'b1;
    for (genvar i = 0; i < CH_CNT; i++) begin : g_ch
        aidc_lite_cfg_chan #(.LEN_LSB(LEN_LSB)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .we      (commit && ch == 4'(i)),
            .rg      (rg),
            .wdata   (apb_if.pwdata),
            .done_in (done_i[i]),
            .src     (src_addr_o[i]),
            .dst     (dst_addr_o[i]),
            .len     (len_o[i]),
            .start   (start_o[i]),
            .st      (st[i]),
            .irq_en  (irq_en[i])
        );
        assign irq_stat[i] = st[i].done & irq_en[i];
    end
    always_comb begin
        rdata = '0;
        if (ch == GLOBAL_PAGE) rdata = rg == REG_IRQ_STAT ? 32'(irq_stat) : '0;
        for (int n = 0; n < CH_CNT; n++)
            if (ch == 4'(n))
                rdata = rg == REG_SRC    ? src_addr_o[n] :
                        rg == REG_DST    ? dst_addr_o[n] :
                        rg == REG_LEN    ? {len_o[n], {LEN_LSB{1'b0}}} :
                        rg == REG_STATUS ? 32'(st[n]) :
                        rg == REG_IRQ_EN ? {31'b0, irq_en[n]} : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) apb_if.prdata <= '0;
        else if (setup) apb_if.prdata <= rdata;
    end
`ifdef AIDC_LITE_CFG_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq_o <= 1'b0;
        else irq_o <= |irq_stat;
    end
`else
    assign irq_o = 1'b0;
`endif
endmodule
